// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the sram-like to AXI3 bridge: tie-offs, size and response encodings.
package sram_axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [3:0] LEN_SINGLE   = 4'h0;
  localparam logic [1:0] LOCK_NORMAL  = 2'b00;
  localparam logic [3:0] CACHE_NONE   = 4'h0;
  localparam logic [2:0] PROT_NONE    = 3'h0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sram_size_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_arbiter.sv
// Single-grant arbiter: fixed priority (highest index wins) or round-robin from a pointer.
module bridge_arbiter #(
  parameter int NPORT  = 2,
  parameter int IDX_W  = 4,
  parameter int RR_ARB = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NPORT-1:0] eligible,
  output logic [NPORT-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int unsigned NP = NPORT;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    idx       = 0;
    if (RR_ARB != 0) begin
      // Search upward from the pointer; the winner's successor leads next time.
      for (int unsigned k = 0; k < NP; k++) begin
        idx = (32'(ptr_q) + k) % NP;
        if (!found && eligible[idx]) begin
          found          = 1'b1;
          grant[idx]     = 1'b1;
          grant_idx      = IDX_W'(idx);
        end
      end
      if (found) begin
        ptr_d = (32'(grant_idx) + 32'd1 >= NP) ? '0 : grant_idx + IDX_W'(1);
      end
    end else begin
      for (int unsigned k = 0; k < NP; k++) begin
        if (eligible[k]) begin
          grant     = '0;
          grant[k]  = 1'b1;
          grant_idx = IDX_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// NPORT sram-like request ports onto one AXI3 master; one outstanding transaction per port,
// reads returned by ID, reads to an in-flight write's word held until its B response.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int ID_W   = 4,
  parameter int RR_ARB = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      sram_req,
  input  logic [NPORT-1:0]      sram_wr,
  input  logic [2*NPORT-1:0]    sram_size,
  input  logic [4*NPORT-1:0]    sram_wstrb,
  input  logic [32*NPORT-1:0]   sram_addr,
  input  logic [32*NPORT-1:0]   sram_wdata,
  output logic [NPORT-1:0]      sram_addr_ok,
  output logic [NPORT-1:0]      sram_data_ok,
  output logic [32*NPORT-1:0]   sram_rdata,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [31:0]           awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  logic [NPORT-1:0] pend_q, pend_d;
  logic             arvalid_q, arvalid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [2:0]       arsize_q, arsize_d;
  logic [ID_W-1:0]  arid_q, arid_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             wr_pend_q, wr_pend_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [2:0]       awsize_q, awsize_d;
  logic [ID_W-1:0]  awid_q, awid_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic [NPORT-1:0] raw_hit, rd_elig, wr_elig, rd_gnt, wr_gnt, r_ret, b_ret;
  logic [ID_W-1:0]  rd_idx, wr_idx;
  logic [31:0]      rd_addr_sel, wr_addr_sel, wr_data_sel;
  logic [1:0]       rd_size_sel, wr_size_sel;
  logic [3:0]       wr_strb_sel;
  logic             unused_inputs;

  assign unused_inputs = ^{rresp, bresp, rlast};

  always_comb begin
    raw_hit = '0;
    rd_elig = '0;
    wr_elig = '0;
    r_ret   = '0;
    b_ret   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      raw_hit[i] = wr_pend_q && (sram_addr[32*i+2 +: 30] == awaddr_q[31:2]);
      rd_elig[i] = resetn && sram_req[i] && !sram_wr[i] && !pend_q[i]
                   && !arvalid_q && !raw_hit[i];
      wr_elig[i] = resetn && sram_req[i] && sram_wr[i] && !pend_q[i]
                   && !awvalid_q && !wvalid_q && !wr_pend_q;
      r_ret[i]   = rvalid && (rid == ID_W'(i)) && pend_q[i];
      b_ret[i]   = bvalid && wr_pend_q && (bid == ID_W'(i));
    end
  end

  bridge_arbiter #(.NPORT(NPORT), .IDX_W(ID_W), .RR_ARB(RR_ARB)) u_rd_arb (
    .clk       (clk),
    .resetn    (resetn),
    .eligible  (rd_elig),
    .grant     (rd_gnt),
    .grant_idx (rd_idx)
  );

  bridge_arbiter #(.NPORT(NPORT), .IDX_W(ID_W), .RR_ARB(RR_ARB)) u_wr_arb (
    .clk       (clk),
    .resetn    (resetn),
    .eligible  (wr_elig),
    .grant     (wr_gnt),
    .grant_idx (wr_idx)
  );

  always_comb begin
    rd_addr_sel = '0;
    rd_size_sel = '0;
    wr_addr_sel = '0;
    wr_size_sel = '0;
    wr_data_sel = '0;
    wr_strb_sel = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (rd_gnt[i]) begin
        rd_addr_sel |= sram_addr[32*i +: 32];
        rd_size_sel |= sram_size[2*i +: 2];
      end
      if (wr_gnt[i]) begin
        wr_addr_sel |= sram_addr[32*i +: 32];
        wr_size_sel |= sram_size[2*i +: 2];
        wr_data_sel |= sram_wdata[32*i +: 32];
        wr_strb_sel |= sram_wstrb[4*i +: 4];
      end
    end
  end

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arid_d    = arid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wr_pend_d = wr_pend_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    awid_d    = awid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    if (|rd_gnt) begin
      arvalid_d = 1'b1;
      araddr_d  = rd_addr_sel;
      arsize_d  = axi_size(rd_size_sel);
      arid_d    = rd_idx;
    end else if (arready) begin
      arvalid_d = 1'b0;
    end

    // awaddr_q doubles as the hazard address until B returns.
    if (|wr_gnt) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      wr_pend_d = 1'b1;
      awaddr_d  = wr_addr_sel;
      awsize_d  = axi_size(wr_size_sel);
      awid_d    = wr_idx;
      wdata_d   = wr_data_sel;
      wstrb_d   = wr_strb_sel;
    end else begin
      if (awready) awvalid_d = 1'b0;
      if (wready)  wvalid_d  = 1'b0;
      if (bvalid)  wr_pend_d = 1'b0;
    end

    pend_d = (pend_q | rd_gnt | wr_gnt) & ~(r_ret | b_ret);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q    <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arid_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      awid_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arid_q    <= arid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_pend_q <= wr_pend_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      awid_q    <= awid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign sram_addr_ok = rd_gnt | wr_gnt;
  assign sram_data_ok = r_ret | b_ret;
  assign sram_rdata   = {NPORT{rdata}};

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign rready  = resetn;

  assign awid    = awid_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_NORMAL;
  assign awcache = CACHE_NONE;
  assign awprot  = PROT_NONE;

  assign wid     = awid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = resetn;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a fixed-priority instance checked against a response
// scoreboard, plus a round-robin instance sharing the stimulus for the arbitration-order check.
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;

  localparam int NP = 2;
  localparam int IW = 4;

  typedef struct packed {
    logic [1:0]  mask;
    logic        rd;
    logic [31:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [NP-1:0]    s_req, s_wr;
  logic [2*NP-1:0]  s_size;
  logic [4*NP-1:0]  s_wstrb;
  logic [32*NP-1:0] s_addr, s_wdata;
  logic             arready, rvalid, rlast, awready, wready, bvalid;
  logic [IW-1:0]    rid, bid;
  logic [31:0]      rdata;
  logic [1:0]       rresp, bresp;

  logic [NP-1:0]    s_aok, s_dok, r_aok, r_dok;
  logic [32*NP-1:0] s_rdata, r_rdata;
  logic [IW-1:0]    arid, awid, wid, r_arid, r_awid, r_wid;
  logic [31:0]      araddr, awaddr, wdata_o, r_araddr, r_awaddr, r_wdata_o;
  logic [3:0]       arlen, awlen, arcache, awcache, wstrb_o;
  logic [3:0]       r_arlen, r_awlen, r_arcache, r_awcache, r_wstrb_o;
  logic [2:0]       arsize, awsize, arprot, awprot, r_arsize, r_awsize, r_arprot, r_awprot;
  logic [1:0]       arburst, awburst, arlock, awlock, r_arburst, r_awburst, r_arlock, r_awlock;
  logic             arvalid, awvalid, wvalid, wlast, rready, bready;
  logic             r_arvalid, r_awvalid, r_wvalid, r_wlast, r_rready, r_bready;

  sram_axi_bridge #(.NPORT(NP), .ID_W(IW), .RR_ARB(0)) dut (
    .clk(clk), .resetn(resetn),
    .sram_req(s_req), .sram_wr(s_wr), .sram_size(s_size), .sram_wstrb(s_wstrb),
    .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(s_aok), .sram_data_ok(s_dok), .sram_rdata(s_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata_o), .wstrb(wstrb_o), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  sram_axi_bridge #(.NPORT(NP), .ID_W(IW), .RR_ARB(1)) dut_rr (
    .clk(clk), .resetn(resetn),
    .sram_req(s_req), .sram_wr(s_wr), .sram_size(s_size), .sram_wstrb(s_wstrb),
    .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(r_aok), .sram_data_ok(r_dok), .sram_rdata(r_rdata),
    .arid(r_arid), .araddr(r_araddr), .arlen(r_arlen), .arsize(r_arsize), .arburst(r_arburst),
    .arlock(r_arlock), .arcache(r_arcache), .arprot(r_arprot), .arvalid(r_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(r_rready),
    .awid(r_awid), .awaddr(r_awaddr), .awlen(r_awlen), .awsize(r_awsize), .awburst(r_awburst),
    .awlock(r_awlock), .awcache(r_awcache), .awprot(r_awprot), .awvalid(r_awvalid), .awready(awready),
    .wid(r_wid), .wdata(r_wdata_o), .wstrb(r_wstrb_o), .wlast(r_wlast), .wvalid(r_wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(r_bready)
  );

  int  checks = 0;
  int  errors = 0;
  bit  use_rr = 1'b0;
  bit  sb_en  = 1'b1;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ret(input logic [1:0] m, input logic rd, input logic [31:0] d);
    sb.push_back('{mask: m, rd: rd, rdata: d});
  endtask

  // Called right after driving a cycle's inputs at the falling edge.
  task automatic step(input logic [1:0] exp_aok);
    sb_t e;
    #1;
    chk("addr_ok", use_rr ? 32'(r_aok) : 32'(s_aok), 32'(exp_aok));
    if (sb_en) begin
      e = '0;
      if (sb.size() != 0) e = sb.pop_front();
      chk("data_ok", 32'(s_dok), 32'(e.mask));
      if (e.rd) begin
        chk("rdata_p0", s_rdata[31:0], e.rdata);
        chk("rdata_p1", s_rdata[63:32], e.rdata);
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clr_req();
    s_req = '0;
    s_wr  = '0;
  endtask

  task automatic rd_req(input int p, input logic [31:0] a);
    s_req[p]          = 1'b1;
    s_wr[p]           = 1'b0;
    s_addr[32*p +: 32] = a;
    s_size[2*p +: 2]  = SZ_WORD;
  endtask

  task automatic wr_req(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input logic [1:0] sz);
    s_req[p]            = 1'b1;
    s_wr[p]             = 1'b1;
    s_addr[32*p +: 32]  = a;
    s_wdata[32*p +: 32] = d;
    s_wstrb[4*p +: 4]   = st;
    s_size[2*p +: 2]    = sz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          win [4];
    logic [1:0]  m;
    win = '{1, 0, 1, 0};
    resetn = 1'b0;
    s_req = '0; s_wr = '0; s_size = '0; s_wstrb = '0; s_addr = '0; s_wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b1; rid = '0; rdata = '0; rresp = RESP_OKAY;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = RESP_OKAY;
    repeat (2) nxt();

    // Reset: a request while resetn is low is not accepted
    rd_req(0, 32'h1c000000);
    step(2'b00);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    nxt();
    clr_req(); resetn = 1'b1;
    step(2'b00);
    chk("rready", 32'(rready), 1);
    chk("bready", 32'(bready), 1);
    chk("arlen", 32'(arlen), 0);
    chk("arburst", 32'(arburst), 32'h1);
    chk("awburst", 32'(awburst), 32'h1);
    nxt();

    // Test 1: single fetch read
    rd_req(0, 32'h1c000000); arready = 1'b1;
    step(2'b01);
    chk("t1_arvalid_c0", 32'(arvalid), 0);
    nxt();
    clr_req();
    step(2'b00);
    chk("t1_arvalid_c1", 32'(arvalid), 1);
    chk("t1_araddr", araddr, 32'h1c000000);
    chk("t1_arid", 32'(arid), 0);
    chk("t1_arsize", 32'(arsize), 2);
    nxt();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c0c;
    expect_ret(2'b01, 1'b1, 32'h02800c0c);
    step(2'b00);
    chk("t1_arvalid_c2", 32'(arvalid), 0);
    nxt();
    rvalid = 1'b0;
    step(2'b00);
    nxt();

    // Test 2: simultaneous reads, fixed priority, highest index first
    arready = 1'b0;
    rd_req(0, 32'h00000100); rd_req(1, 32'h00000200);
    step(2'b10);
    nxt();
    arready = 1'b1;
    step(2'b00);
    chk("t2_arvalid_a", 32'(arvalid), 1);
    chk("t2_arid_a", 32'(arid), 1);
    chk("t2_araddr_a", araddr, 32'h200);
    nxt();
    step(2'b01);
    chk("t2_arvalid_gap", 32'(arvalid), 0);
    nxt();
    clr_req();
    step(2'b00);
    chk("t2_arid_b", 32'(arid), 0);
    chk("t2_araddr_b", araddr, 32'h100);
    nxt();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'haaaa0000;
    expect_ret(2'b01, 1'b1, 32'haaaa0000);
    step(2'b00);
    nxt();
    rid = 4'd1; rdata = 32'hbbbb1111;
    expect_ret(2'b10, 1'b1, 32'hbbbb1111);
    step(2'b00);
    nxt();
    rid = 4'd5; rdata = 32'hdeaddead;
    step(2'b00);
    nxt();
    rid = 4'd1;
    step(2'b00);
    nxt();
    rvalid = 1'b0;

    // Test 3: write with immediate wready, awready after 3 cycles
    awready = 1'b0; wready = 1'b1;
    wr_req(1, 32'h00001000, 32'h12345678, 4'h3, SZ_HALF);
    step(2'b10);
    nxt();
    clr_req();
    step(2'b00);
    chk("t3_awvalid_1", 32'(awvalid), 1);
    chk("t3_wvalid_1", 32'(wvalid), 1);
    chk("t3_wlast", 32'(wlast), 1);
    chk("t3_awid", 32'(awid), 1);
    chk("t3_wid", 32'(wid), 1);
    chk("t3_awaddr", awaddr, 32'h1000);
    chk("t3_awsize", 32'(awsize), 1);
    chk("t3_wstrb", 32'(wstrb_o), 32'h3);
    chk("t3_wdata", wdata_o, 32'h12345678);
    nxt();
    step(2'b00);
    chk("t3_awvalid_2", 32'(awvalid), 1);
    chk("t3_wvalid_2", 32'(wvalid), 0);
    nxt();
    awready = 1'b1;
    step(2'b00);
    chk("t3_awvalid_3", 32'(awvalid), 1);
    nxt();

    // Test 4: read to the in-flight write's word waits for B plus one cycle
    awready = 1'b0;
    rd_req(0, 32'h00001000);
    step(2'b00);
    chk("t3_awvalid_4", 32'(awvalid), 0);
    nxt();
    step(2'b00);
    nxt();
    bvalid = 1'b1; bid = 4'd1;
    expect_ret(2'b10, 1'b0, 32'h0);
    step(2'b00);
    nxt();
    bvalid = 1'b0;
    step(2'b01);
    nxt();
    clr_req();
    step(2'b00);
    chk("t4_arvalid", 32'(arvalid), 1);
    chk("t4_araddr", araddr, 32'h1000);
    nxt();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0f0f0f0f;
    expect_ret(2'b01, 1'b1, 32'h0f0f0f0f);
    step(2'b00);
    nxt();
    rvalid = 1'b0;

    // Test 4b: neighbouring word is not a hazard; R and B return together
    awready = 1'b1; wready = 1'b1;
    wr_req(1, 32'h00001000, 32'hcafef00d, 4'hf, SZ_WORD);
    step(2'b10);
    nxt();
    clr_req();
    rd_req(0, 32'h00001004);
    step(2'b01);
    chk("t4b_awvalid", 32'(awvalid), 1);
    nxt();
    clr_req();
    step(2'b00);
    chk("t4b_arvalid", 32'(arvalid), 1);
    chk("t4b_araddr", araddr, 32'h1004);
    nxt();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h5a5a5a5a;
    bvalid = 1'b1; bid = 4'd1;
    expect_ret(2'b11, 1'b1, 32'h5a5a5a5a);
    step(2'b00);
    nxt();
    rvalid = 1'b0; bvalid = 1'b0;
    step(2'b00);
    nxt();

    // Test 5: round-robin instance alternates when both ports contend
    resetn = 1'b0;
    nxt();
    resetn = 1'b1;
    sb.delete();
    use_rr = 1'b1; sb_en = 1'b0;
    nxt();
    rd_req(0, 32'h00000040);
    step(2'b01);
    nxt();
    clr_req();
    step(2'b00);
    nxt();
    rvalid = 1'b1; rid = 4'd0;
    step(2'b00);
    nxt();
    rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = '0;
      m[win[k]] = 1'b1;
      rd_req(0, 32'h00000040); rd_req(1, 32'h00000080);
      step(m);
      nxt();
      clr_req();
      step(2'b00);
      chk("t5_arid", 32'(r_arid), 32'(win[k]));
      nxt();
      rvalid = 1'b1; rid = IW'(win[k]);
      step(2'b00);
      nxt();
      rvalid = 1'b0;
    end

    // Test 6: reset while a read is in flight drops its late response
    resetn = 1'b0;
    nxt();
    resetn = 1'b1;
    sb.delete();
    use_rr = 1'b0; sb_en = 1'b1;
    arready = 1'b0;
    nxt();
    rd_req(0, 32'h00002000);
    step(2'b01);
    nxt();
    clr_req();
    step(2'b00);
    chk("t6_arvalid_before", 32'(arvalid), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_arvalid_async", 32'(arvalid), 0);
    chk("t6_data_ok_rst", 32'(s_dok), 0);
    nxt();
    resetn = 1'b1;
    step(2'b00);
    nxt();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h77777777;
    step(2'b00);
    chk("t6_arvalid_after", 32'(arvalid), 0);
    nxt();
    rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts NPORT sram-like request ports (req/addr_ok/data_ok) into one AXI3-style master. It sits between the CPU core and the SoC bus, and succeeds the direct inst/data sram hookup at the CPU top. Port 0 is the fetch port and port NPORT-1 is the data port. Features: per-port outstanding tracking, arbitration, out-of-order read return by ID, and a read-after-write address hazard check.

Parameters:
NPORT, 2, number of sram-like ports; legal range 1..15; ID = port index.
ID_W, 4, AXI id width; must satisfy 2^ID_W > NPORT.
RR_ARB, 0, 0 = fixed priority with highest index winning; 1 = round-robin.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous active-low; all state cleared while low
sram_req  in  NPORT  request per port
sram_wr  in  NPORT  1 = write
sram_size  in  2*NPORT  0/1/2 = byte/half/word
sram_wstrb  in  4*NPORT  byte strobes
sram_addr  in  32*NPORT  byte address
sram_wdata  in  32*NPORT  write data
sram_addr_ok  out  NPORT  request accepted this cycle
sram_data_ok  out  NPORT  read data valid or write done
sram_rdata  out  32*NPORT  read data (all slices driven from AXI rdata)
arid/araddr/arsize/arvalid  out  ID_W/32/3/1  read address channel
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  read data channel
rready  out  1
awid/awaddr/awsize/awvalid  out  ID_W/32/3/1  write address channel
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  write data channel
wready  in  1
bid/bresp/bvalid  in  ID_W/2/1
bready  out  1
arlen/awlen/arburst/awburst/arlock/awlock/arcache/awcache/arprot/awprot  out  tie-offs: len 0, burst 2'b01, lock/cache/prot 0

Behaviour:
- Reset (resetn=0, async): arvalid=awvalid=wvalid=0; addr_ok=data_ok=0; all pending flags cleared; RR pointer=0. Responses still in flight are dropped because their pending flag is clear.
- rready=bready=1 whenever resetn=1.
- Per-port pending flag: each port has at most one outstanding transaction (read or write). A port with its flag set gets addr_ok=0.
- Read eligibility for port i: req & ~wr & ~pend[i] & ~arvalid_reg & ~raw_hit(i).
- Write eligibility for port i: req & wr & ~pend[i] & ~awvalid_reg & ~wvalid_reg & ~wr_pend.
- raw_hit(i): wr_pend & (addr_i[31:2]==wr_addr[31:2]).
- Arbitration is separate for reads and writes, one grant each per cycle. A read and a write from different ports may both be accepted in the same cycle.
- RR_ARB=1: the pointer advances to the winner+1 after each grant.
- addr_ok is combinational in the grant cycle.
- Read accept: next cycle arvalid=1, araddr=addr, arsize={0,size}, arid=i, pend[i]=1. arvalid holds, with stable fields, until arready.
- R: on rvalid with rid<NPORT and pend[rid]: data_ok[rid]=1 and sram_rdata=rdata in the same cycle; pend[rid] cleared at the clock edge. Other rid values are ignored. rresp is not checked.
- Write accept: next cycle awvalid=wvalid=1, wlast=1, awid=wid=i; wr_pend=1, pend[i]=1. awvalid and wvalid each drop independently on their own ready. wr_addr is held until B.
- B: on bvalid with wr_pend: data_ok[bid]=1; wr_pend and pend[bid] cleared at the clock edge.
- Hazard release: a read blocked by raw_hit may be accepted one cycle after bvalid, not in the same cycle.
- Simultaneous rvalid and bvalid always target different ports (pending exclusivity), so both data_ok bits may assert together.
- addr_ok is not asserted for a port whose data_ok is being returned that cycle; its pend flag is cleared only at the edge.
- Latency: a read completes no earlier than 2 cycles after addr_ok, given zero-wait AXI.

Decomposition:
- Shared package: AXI tie-off constants (BURST_INCR, LEN_SINGLE), size encodings, resp codes.
- Sub-module bridge_arbiter, instantiated twice (read and write): inputs eligible[NPORT] and RR_ARB; outputs a one-hot grant and grant index; holds the RR pointer register.

Test Plan:
1. Port0 reads 0x1c000000 alone; arready=1; rvalid rid=0 rdata=0x02800c0c two cycles later -> addr_ok[0] in cycle 0, arvalid in cycle 1 only, data_ok[0]=1 with rdata 0x02800c0c in the rvalid cycle.
2. Ports 0 and 1 both read in the same cycle, RR_ARB=0 -> addr_ok=2'b10, arid=1; port0 accepted the cycle after arready; responses returned rid 0 then rid 1 -> data_ok 2'b01 then 2'b10.
3. Port1 writes 0x1000, wstrb 0x3, size 1; wready immediate, awready after 3 cycles -> wvalid high 1 cycle, awvalid high 3 cycles; bvalid -> data_ok[1]=1.
4. Write 0x1000 pending; port0 reads 0x1000 -> addr_ok[0]=0 until the cycle after bvalid; repeat with a read of 0x1004 -> accepted immediately.
5. RR_ARB=1, both ports requesting reads continuously -> grants alternate 1,0,1,0.
6. Drop resetn while arvalid=1 and pend[0]=1; a late rvalid rid=0 arrives after release -> arvalid=0 immediately, no data_ok.
